sev_seg_scheduler: RTL and testbench

SEV_SEG_SCHEDULER -- requirements
Module: sev_seg_scheduler

---
 rtl/sev_pkg.sv | 41 ++++
 rtl/sev_seg_decode.sv | 12 +
 rtl/sev_seg_scheduler.sv | 78 +++++++
 tb/tb_sev_seg_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sev_pkg.sv
// Shared constants for the seven-segment scan path:
// blank pattern, hex segment table and anode patterns.
package sev_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] AN_DIG0 = 8'b1111_1110;
    localparam logic [7:0] AN_DIG1 = 8'b1111_1101;
    localparam logic [7:0] AN_DIG2 = 8'b1111_1011;
    localparam logic [7:0] AN_DIG3 = 8'b1111_0111;
    localparam logic [7:0] AN_DIG4 = 8'b1110_1111;
    localparam logic [7:0] AN_DIG5 = 8'b1101_1111;
    localparam logic [7:0] AN_DIG6 = 8'b1011_1111;
    localparam logic [7:0] AN_DIG7 = 8'b0111_1111;

    // Active-low segments, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
        7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
        7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
        7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
    };

    function automatic logic [7:0] an_of(input logic [2:0] d);
        logic [7:0] r;
        r = AN_OFF;
        unique case (d)
            3'd0: r = AN_DIG0;
            3'd1: r = AN_DIG1;
            3'd2: r = AN_DIG2;
            3'd3: r = AN_DIG3;
            3'd4: r = AN_DIG4;
            3'd5: r = AN_DIG5;
            3'd6: r = AN_DIG6;
            3'd7: r = AN_DIG7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup into the shared table.
module sev_seg_decode
    import sev_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/sev_seg_scheduler.sv
// Eight-digit multiplexed display scan with frame-latched
// source snapshot, PWM brightness and leading-zero blanking.
module sev_seg_scheduler
    import sev_pkg::*;
#(
    parameter int SUBTICKS = 8
) (
    input  logic                        clk_7seg,
    input  logic                        Rst,
    input  logic                        dbg_req,
    input  logic [31:0]                 dbg_data,
    input  logic [31:0]                 mmio_data,
    input  logic [7:0]                  dig_mask,
    input  logic                        lzs_en,
    input  logic [$clog2(SUBTICKS)-1:0] bright,
    output logic [7:0]                  an,
    output logic [6:0]                  sev_out,
    output logic                        src_dbg,
    output logic                        frame_start
);

    localparam int TW = $clog2(SUBTICKS);
    localparam logic [TW-1:0] TMAX = TW'(SUBTICKS - 1);

    logic [TW-1:0] tick;
    logic [2:0]    dig;
    logic [31:0]   snap;
    logic [7:0]    supp;
    logic [3:0]    nib;
    logic [6:0]    seg;
    logic          lit;
    logic          wrap;
    logic          boundary;

    assign wrap     = (tick == TMAX);
    assign boundary = wrap && (dig == 3'd7);
    assign nib      = snap[{dig, 2'b00} +: 4];

    // Digit i is a leading zero when everything from it upward is zero.
    always_comb begin
        supp = '0;
        for (int i = 1; i < 8; i++) begin
            supp[i] = lzs_en && ((snap >> (4 * i)) == 32'd0);
        end
    end

    assign lit = (tick <= bright) && dig_mask[dig] && !supp[dig];

    sev_seg_decode u_dec (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            tick        <= '0;
            dig         <= '0;
            snap        <= '0;
            src_dbg     <= 1'b0;
            an          <= AN_OFF;
            sev_out     <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            tick <= tick + 1'b1;
            if (wrap) begin
                dig <= dig + 3'd1;
            end
            if (boundary) begin
                snap    <= dbg_req ? dbg_data : mmio_data;
                src_dbg <= dbg_req;
            end
            an          <= lit ? an_of(dig) : AN_OFF;
            sev_out     <= lit ? seg : SEG_BLANK;
            frame_start <= (dig == 3'd0) && (tick == '0);
        end
    end

endmodule

// File: tb/tb_sev_seg_scheduler.sv
// Scoreboard bench: a cycle model pushes expected outputs,
// the DUT outputs are popped and checked one edge later.
module tb_sev_seg_scheduler;

    localparam int ST = 8;
    localparam int TW = $clog2(ST);

    logic          clk_7seg = 1'b0;
    logic          Rst;
    logic          dbg_req;
    logic [31:0]   dbg_data;
    logic [31:0]   mmio_data;
    logic [7:0]    dig_mask;
    logic          lzs_en;
    logic [TW-1:0] bright;
    logic [7:0]    an;
    logic [6:0]    sev_out;
    logic          src_dbg;
    logic          frame_start;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] sev;
        logic       fs;
        logic       src;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    int          m_tick;
    int          m_dig;
    logic [31:0] m_snap;
    logic        m_src;

    always #5 clk_7seg = ~clk_7seg;

    sev_seg_scheduler #(.SUBTICKS(ST)) dut (
        .clk_7seg    (clk_7seg),
        .Rst         (Rst),
        .dbg_req     (dbg_req),
        .dbg_data    (dbg_data),
        .mmio_data   (mmio_data),
        .dig_mask    (dig_mask),
        .lzs_en      (lzs_en),
        .bright      (bright),
        .an          (an),
        .sev_out     (sev_out),
        .src_dbg     (src_dbg),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model the edge about to happen, then compare after it.
    task automatic cyc();
        exp_t e;
        exp_t g;
        logic lit;
        logic supp;
        logic [3:0] n;
        if (Rst) begin
            e = '{8'hFF, 7'h7F, 1'b0, 1'b0};
            m_tick = 0;
            m_dig  = 0;
            m_snap = 0;
            m_src  = 0;
        end else begin
            supp = lzs_en && (m_dig != 0) &&
                   ((m_snap >> (4 * m_dig)) == 0);
            lit  = (m_tick <= int'(bright)) &&
                   dig_mask[m_dig] && !supp;
            n    = m_snap[4 * m_dig +: 4];
            e.an  = lit ? ~(8'h01 << m_dig) : 8'hFF;
            e.sev = lit ? hexseg(n) : 7'h7F;
            e.fs  = (m_tick == 0) && (m_dig == 0);
            if (m_dig == 7 && m_tick == ST - 1) begin
                m_snap = dbg_req ? dbg_data : mmio_data;
                m_src  = dbg_req;
            end
            e.src = m_src;
            if (m_tick == ST - 1) m_dig = (m_dig + 1) % 8;
            m_tick = (m_tick + 1) % ST;
        end
        q.push_back(e);
        @(posedge clk_7seg);
        #1;
        g = q.pop_front();
        chk("an", 32'(an), 32'(g.an));
        chk("sev_out", 32'(sev_out), 32'(g.sev));
        chk("frame_start", 32'(frame_start), 32'(g.fs));
        chk("src_dbg", 32'(src_dbg), 32'(g.src));
    endtask

    task automatic cycn(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!frame_start && n < 200);
        chk("fs_timeout", 32'(frame_start), 32'd1);
    endtask

    int lows;
    int per;
    int stray;

    initial begin
        Rst       = 1'b1;
        dbg_req   = 1'b0;
        dbg_data  = 32'hFFFF_FFFF;
        mmio_data = 32'h0000_00A5;
        dig_mask  = 8'hFF;
        lzs_en    = 1'b0;
        bright    = TW'(ST - 1);
        m_tick = 0; m_dig = 0; m_snap = 0; m_src = 0;

        cycn(3);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_sev", 32'(sev_out), 32'h7F);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_src", 32'(src_dbg), 32'd0);

        Rst = 1'b0;
        cyc();
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_sev", 32'(sev_out), 32'b0000001);

        wait_fs();
        chk("a5_d0_an", 32'(an), 32'hFE);
        chk("a5_d0", 32'(sev_out), 32'b0100100);
        cycn(ST);
        chk("a5_d1_an", 32'(an), 32'hFD);
        chk("a5_d1", 32'(sev_out), 32'b0001000);
        cycn(ST);
        chk("a5_d2_an", 32'(an), 32'hFB);
        chk("a5_d2", 32'(sev_out), 32'b0000001);

        lzs_en = 1'b1;
        wait_fs();
        chk("lzs_d0", 32'(an), 32'hFE);
        cycn(2 * ST);
        chk("lzs_d2_an", 32'(an), 32'hFF);
        chk("lzs_d2_sev", 32'(sev_out), 32'h7F);
        lzs_en = 1'b0;

        wait_fs();
        cycn(20);
        dbg_req = 1'b1;
        cycn(20);
        chk("no_tear_src", 32'(src_dbg), 32'd0);
        wait_fs();
        chk("dbg_src", 32'(src_dbg), 32'd1);
        chk("dbg_sev", 32'(sev_out), 32'b0111000);

        bright = 2;
        wait_fs();
        lows = 0;
        for (int i = 0; i < 8 * ST; i++) begin
            if (an != 8'hFF) lows++;
            cyc();
        end
        chk("bright2_lows", 32'(lows), 32'd24);

        bright   = TW'(ST - 1);
        dig_mask = 8'b1000_0001;
        wait_fs();
        per = 0;
        stray = 0;
        do begin
            if (an != 8'hFF && an != 8'hFE && an != 8'h7F)
                stray++;
            cyc();
            per++;
        end while (!frame_start && per < 200);
        chk("mask_period", 32'(per), 32'd64);
        chk("mask_stray", 32'(stray), 32'd0);

        wait_fs();
        cycn(4 * ST);
        Rst = 1'b1;
        cyc();
        chk("midrst_an", 32'(an), 32'hFF);
        chk("midrst_sev", 32'(sev_out), 32'h7F);
        Rst = 1'b0;
        cyc();
        chk("midrst_fs", 32'(frame_start), 32'd1);
        chk("midrst_d0", 32'(an), 32'hFE);
        chk("midrst_snap0", 32'(sev_out), 32'b0000001);
        cycn(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
